gpio_rx_capture: RTL and testbench
==================================

Name: gpio_rx_capture

Overview:
- Receive side of the GPIO pin interface. Samples the gpio_pin bus driven by the GPIO UVC driver (or by external pads) into the clk_i domain.
- Per pin: synchronizes, debounces, detects rising and falling edges, and keeps sticky edge status that drives a single level interrupt.
- Sits between the GPIO pad/UVC boundary and the register/interrupt fabric.

Parameters:
- WIDTH, 8: number of GPIO pins handled.
- SYNC_STAGES, 2: synchronizer flop depth per pin. Must be >= 2.
- DEBOUNCE_CYCLES, 4: consecutive differing synchronized samples required before the filtered level changes. Must be >= 1.

Ports:
- clk_i  input  1  block clock.
- rst_ni  input  1  asynchronous active-low reset.
- gpio_pin_i  input  WIDTH  raw pin values, asynchronous to clk_i.
- rise_en_i  input  WIDTH  per-pin enable for recording rising edges in status.
- fall_en_i  input  WIDTH  per-pin enable for recording falling edges in status.
- status_clr_i  input  WIDTH  per-pin status clear, sampled each cycle (write-1-to-clear strobe).
- gpio_level_o  output  WIDTH  debounced pin level.
- rise_o  output  WIDTH  one-cycle pulse per debounced 0->1 transition.
- fall_o  output  WIDTH  one-cycle pulse per debounced 1->0 transition.
- status_o  output  WIDTH  sticky enabled-edge status.
- irq_o  output  1  interrupt, combinational OR of status_o.

Behaviour:
- One clock domain: clk_i. Reset is asynchronous, active-low on rst_ni. All flops are cleared on rst_ni low, independent of clk_i.
- Reset values:
  - synchronizer flops, debounce counters, gpio_level_o, rise_o, fall_o, status_o are all 0.
  - irq_o is 0.
- Synchronizer: SYNC_STAGES flops per bit. No logic between stages. The last stage output is sync[i].
- Debounce, per bit, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If sync[i] == gpio_level_o[i]: counter is cleared to 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: gpio_level_o[i] <= sync[i] and counter <= 0.
  - Else: counter increments by 1.
  - The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Latency: gpio_level_o changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge of clk_i, counting as the 1st edge the first one that samples the new pin value. Defaults give the 6th edge.
- Glitch rejection: a pin excursion sampled on fewer than DEBOUNCE_CYCLES consecutive edges never reaches gpio_level_o. The counter restarts from 0 on any return to the current level.
- Edge pulses:
  - rise_o[i] is registered and asserted for exactly the cycle in which gpio_level_o[i] is first 1 after being 0.
  - fall_o[i] is the same for 1->0.
  - rise_o[i] and fall_o[i] are never asserted together.
  - Pulses are not gated by the enables.
- Status, per bit:
  - set = (rise_o[i] & rise_en_i[i]) | (fall_o[i] & fall_en_i[i]).
  - status_o[i] <= set ? 1 : (status_clr_i[i] ? 0 : status_o[i]).
  - Set and clear in the same cycle: set wins, status stays 1.
  - Status updates on the edge after the pulse cycle.
  - Clearing enables does not clear status already recorded.
- irq_o = |status_o, with no added latency. It stays high until every set bit is cleared.
- Pin held high across reset release: gpio_level_o starts at 0, so a rising edge is reported after the normal latency. This is intended behaviour.
- Reset mid-debounce: the counter and level are forced to 0 immediately. Any partial debounce is discarded and no pulse is generated by the reset itself.
- Bits are fully independent. Simultaneous transitions on several pins each produce their own pulse and status in the same cycle.

Test Plan:
- Reset check: hold rst_ni=0, toggle gpio_pin_i and clk_i. All outputs must stay 0. Deassert rst_ni with gpio_pin_i=0; outputs remain 0 for 20 cycles.
- Latency, defaults: drive gpio_pin_i[0] 0->1 before an edge, with rise_en_i[0]=1. Then:
  - gpio_level_o[0]=1 and rise_o[0]=1 for exactly one cycle on the 6th edge.
  - status_o[0]=1 and irq_o=1 from the 7th edge.
- Glitch filtering: pulse gpio_pin_i[3] high for exactly 3 clock periods. gpio_level_o[3], rise_o[3] and fall_o[3] stay 0. Repeat with 4 periods: rise_o[3] fires, then fall_o[3] fires 4 cycles later.
- Enable gating: rise_en_i=0x00, fall_en_i=0xFF. Toggle pin 5 0->1->0 with stable periods of 10 cycles. rise_o[5] and fall_o[5] both pulse, but only the fall sets status_o[5]=1.
- Clear versus set: with status_o[2]=1, assert status_clr_i[2] in the same cycle a new enabled edge is pending. status_o[2] stays 1. Assert the clear alone next cycle: status_o[2]=0 and irq_o=0.
- Multi-pin and reset mid-debounce:
  - Drive gpio_pin_i 0x00->0xA5 simultaneously. rise_o must equal 0xA5 in a single cycle.
  - Then drive 0x00, and assert rst_ni low 2 cycles into the debounce. All outputs go to 0 immediately, with no fall pulse after release.

Source files
------------

// File: rtl/gpio_rx_capture.sv
// gpio_rx_capture
//   Receive side of the GPIO pin interface. Each pin is brought into the
//   clk_i domain through a synchronizer chain. It is then debounced and
//   edge-detected. Enabled edges are recorded in sticky status bits, and
//   the OR of those bits drives a level interrupt.
//
// Ports
//   clk_i         block clock
//   rst_ni        asynchronous active-low reset
//   gpio_pin_i    raw pin values, asynchronous to clk_i
//   rise_en_i     per-pin enable for recording rising edges in status
//   fall_en_i     per-pin enable for recording falling edges in status
//   status_clr_i  per-pin write-1-to-clear strobe for status
//   gpio_level_o  debounced pin level
//   rise_o        one-cycle pulse per debounced 0->1 transition
//   fall_o        one-cycle pulse per debounced 1->0 transition
//   status_o      sticky enabled-edge status
//   irq_o         OR of status_o
module gpio_rx_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] gpio_pin_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] status_clr_i,
  output logic [WIDTH-1:0] gpio_level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] status_o,
  output logic             irq_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   level_reg;
    logic                   level_next;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   status_reg;
    logic                   status_set;

    // Plain shift chain: stage 0 samples the pin, the top stage is the
    // synchronized value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_pin_i[gi]};
      end
    end

    assign sync_bit = sync_reg[SYNC_STAGES-1];

    // Debounce: count consecutive samples that differ from the filtered
    // level. Any sample matching the level restarts the count from zero.
    always_comb begin
      cnt_next   = '0;
      level_next = level_reg;
      if (sync_bit != level_reg) begin
        if (cnt_reg == CNT_MAX) begin
          level_next = sync_bit;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end

    // A set that arrives together with a clear wins. This way an edge that
    // lands during a clear is not lost.
    assign status_set = (rise_reg & rise_en_i[gi]) | (fall_reg & fall_en_i[gi]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_reg    <= '0;
        level_reg  <= 1'b0;
        rise_reg   <= 1'b0;
        fall_reg   <= 1'b0;
        status_reg <= 1'b0;
      end else begin
        cnt_reg   <= cnt_next;
        level_reg <= level_next;
        // The pulses are registered together with the level. Each one is
        // therefore high in the first cycle the new level is visible.
        rise_reg  <= level_next & ~level_reg;
        fall_reg  <= ~level_next & level_reg;
        if (status_set) begin
          status_reg <= 1'b1;
        end else if (status_clr_i[gi]) begin
          status_reg <= 1'b0;
        end
      end
    end

    assign gpio_level_o[gi] = level_reg;
    assign rise_o[gi]       = rise_reg;
    assign fall_o[gi]       = fall_reg;
    assign status_o[gi]     = status_reg;
  end

  assign irq_o = |status_o;

endmodule

// File: tb/tb_gpio_rx_capture.sv
// tb_gpio_rx_capture
//   Directed bench for gpio_rx_capture with the default parameters
//   (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4). The debounced level
//   changes on the 6th edge after a pin change. One scenario task per
//   feature, each doing its own comparisons.
module tb_gpio_rx_capture;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] gpio_pin_i;
  logic [7:0] rise_en_i;
  logic [7:0] fall_en_i;
  logic [7:0] status_clr_i;
  logic [7:0] gpio_level_o;
  logic [7:0] rise_o;
  logic [7:0] fall_o;
  logic [7:0] status_o;
  logic       irq_o;

  int errors = 0;
  int checks = 0;

  gpio_rx_capture #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .gpio_pin_i(gpio_pin_i),
    .rise_en_i(rise_en_i),
    .fall_en_i(fall_en_i),
    .status_clr_i(status_clr_i),
    .gpio_level_o(gpio_level_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .status_o(status_o),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle 1 ns past it. Inputs driven after
  // a tick are first sampled by the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    gpio_pin_i = 8'h00;
    rise_en_i = 8'h00;
    fall_en_i = 8'h00;
    status_clr_i = 8'h00;
    #2;
    for (int c = 0; c < 8; c++) begin
      gpio_pin_i = (c % 2 == 0) ? 8'hFF : 8'h3C;
      tick();
      checks++;
      if ({gpio_level_o, rise_o, fall_o, status_o, irq_o} !== 33'd0) begin
        errors++;
        $display("FAIL reset_hold c=%0d: got lvl=%h rise=%h fall=%h st=%h irq=%b required all 0",
                 c, gpio_level_o, rise_o, fall_o, status_o, irq_o);
      end
    end
    gpio_pin_i = 8'h00;
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({gpio_level_o, rise_o, fall_o, status_o, irq_o} !== 33'd0) begin
        errors++;
        $display("FAIL reset_release c=%0d: got lvl=%h rise=%h fall=%h st=%h irq=%b required all 0",
                 c, gpio_level_o, rise_o, fall_o, status_o, irq_o);
      end
    end
    $display("test_reset done (checks=%0d errors=%0d)", checks, errors);
  endtask

  task automatic test_latency();
    logic exp_lvl;
    logic exp_rise;
    logic exp_st;
    rise_en_i = 8'h01;
    gpio_pin_i = 8'h01;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_lvl  = (e >= 6);
      exp_rise = (e == 6);
      exp_st   = (e >= 7);
      checks++;
      if (gpio_level_o[0] !== exp_lvl || rise_o[0] !== exp_rise || fall_o[0] !== 1'b0 ||
          status_o[0] !== exp_st || irq_o !== exp_st) begin
        errors++;
        $display("FAIL latency edge=%0d: got lvl=%b rise=%b fall=%b st=%b irq=%b required lvl=%b rise=%b fall=0 st=%b irq=%b",
                 e, gpio_level_o[0], rise_o[0], fall_o[0], status_o[0], irq_o,
                 exp_lvl, exp_rise, exp_st, exp_st);
      end
    end
    // Clear the status, then return the pin low while fall recording is disabled.
    status_clr_i = 8'h01;
    tick();
    status_clr_i = 8'h00;
    gpio_pin_i = 8'h00;
    checks++;
    if (status_o[0] !== 1'b0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_clear: got st=%b irq=%b required 0 0", status_o[0], irq_o);
    end
    for (int e = 0; e < 8; e++) tick();
    checks++;
    if (gpio_level_o !== 8'h00 || status_o !== 8'h00) begin
      errors++;
      $display("FAIL latency_return: got lvl=%h st=%h required 00 00", gpio_level_o, status_o);
    end
    rise_en_i = 8'h00;
    $display("test_latency done (checks=%0d errors=%0d)", checks, errors);
  endtask

  task automatic test_glitch();
    logic exp_rise;
    logic exp_fall;
    logic exp_lvl;
    // A 3-period excursion must be filtered out.
    gpio_pin_i[3] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) gpio_pin_i[3] = 1'b0;
      tick();
      checks++;
      if (gpio_level_o[3] !== 1'b0 || rise_o[3] !== 1'b0 || fall_o[3] !== 1'b0) begin
        errors++;
        $display("FAIL glitch3 edge=%0d: got lvl=%b rise=%b fall=%b required 0 0 0",
                 e, gpio_level_o[3], rise_o[3], fall_o[3]);
      end
    end
    // A 4-period excursion passes. It rises on edge 6 and falls on edge 10.
    gpio_pin_i[3] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      if (e == 5) gpio_pin_i[3] = 1'b0;
      tick();
      exp_rise = (e == 6);
      exp_fall = (e == 10);
      exp_lvl  = (e >= 6 && e < 10);
      checks++;
      if (gpio_level_o[3] !== exp_lvl || rise_o[3] !== exp_rise || fall_o[3] !== exp_fall) begin
        errors++;
        $display("FAIL glitch4 edge=%0d: got lvl=%b rise=%b fall=%b required %b %b %b",
                 e, gpio_level_o[3], rise_o[3], fall_o[3], exp_lvl, exp_rise, exp_fall);
      end
    end
    $display("test_glitch done (checks=%0d errors=%0d)", checks, errors);
  endtask

  task automatic test_enable();
    int rise_seen;
    int fall_seen;
    rise_seen = 0;
    fall_seen = 0;
    rise_en_i = 8'h00;
    fall_en_i = 8'hFF;
    gpio_pin_i[5] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (rise_o[5]) rise_seen++;
    end
    checks++;
    if (rise_seen != 1 || status_o[5] !== 1'b0 || gpio_level_o[5] !== 1'b1) begin
      errors++;
      $display("FAIL enable_rise: got pulses=%0d st=%b lvl=%b required 1 0 1",
               rise_seen, status_o[5], gpio_level_o[5]);
    end
    gpio_pin_i[5] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (fall_o[5]) fall_seen++;
    end
    checks++;
    if (fall_seen != 1 || status_o !== 8'h20 || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL enable_fall: got pulses=%0d st=%h irq=%b required 1 20 1",
               fall_seen, status_o, irq_o);
    end
    // Clearing the enables must leave recorded status in place.
    fall_en_i = 8'h00;
    tick();
    checks++;
    if (status_o[5] !== 1'b1) begin
      errors++;
      $display("FAIL enable_sticky: got st5=%b required 1", status_o[5]);
    end
    status_clr_i = 8'hFF;
    tick();
    status_clr_i = 8'h00;
    checks++;
    if (status_o !== 8'h00 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL enable_clear: got st=%h irq=%b required 00 0", status_o, irq_o);
    end
    $display("test_enable done (checks=%0d errors=%0d)", checks, errors);
  endtask

  task automatic test_clear_vs_set();
    rise_en_i = 8'h04;
    fall_en_i = 8'h04;
    gpio_pin_i[2] = 1'b1;
    for (int e = 0; e < 7; e++) tick();
    checks++;
    if (status_o[2] !== 1'b1 || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: got st2=%b irq=%b required 1 1", status_o[2], irq_o);
    end
    gpio_pin_i[2] = 1'b0;
    for (int e = 0; e < 6; e++) tick();
    checks++;
    if (fall_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL clr_fall_pulse: got fall2=%b required 1", fall_o[2]);
    end
    // The pending fall sets status on the same edge that the clear is sampled.
    status_clr_i = 8'h04;
    tick();
    checks++;
    if (status_o[2] !== 1'b1 || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL clr_set_wins: got st2=%b irq=%b required 1 1", status_o[2], irq_o);
    end
    tick();
    status_clr_i = 8'h00;
    checks++;
    if (status_o[2] !== 1'b0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: got st2=%b irq=%b required 0 0", status_o[2], irq_o);
    end
    rise_en_i = 8'h00;
    fall_en_i = 8'h00;
    $display("test_clear_vs_set done (checks=%0d errors=%0d)", checks, errors);
  endtask

  task automatic test_multi_reset();
    rise_en_i = 8'hFF;
    fall_en_i = 8'hFF;
    gpio_pin_i = 8'hA5;
    for (int e = 1; e <= 5; e++) tick();
    checks++;
    if (rise_o !== 8'h00 || gpio_level_o !== 8'h00) begin
      errors++;
      $display("FAIL multi_early: got rise=%h lvl=%h required 00 00", rise_o, gpio_level_o);
    end
    tick();
    checks++;
    if (rise_o !== 8'hA5 || gpio_level_o !== 8'hA5 || fall_o !== 8'h00) begin
      errors++;
      $display("FAIL multi_rise: got rise=%h lvl=%h fall=%h required A5 A5 00",
               rise_o, gpio_level_o, fall_o);
    end
    tick();
    checks++;
    if (rise_o !== 8'h00 || status_o !== 8'hA5 || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL multi_status: got rise=%h st=%h irq=%b required 00 A5 1",
               rise_o, status_o, irq_o);
    end
    // Drive the pins low. After 4 edges the counters are 2 into the debounce.
    gpio_pin_i = 8'h00;
    for (int e = 0; e < 4; e++) tick();
    checks++;
    if (gpio_level_o !== 8'hA5 || fall_o !== 8'h00) begin
      errors++;
      $display("FAIL multi_pre_reset: got lvl=%h fall=%h required A5 00", gpio_level_o, fall_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({gpio_level_o, rise_o, fall_o, status_o, irq_o} !== 33'd0) begin
      errors++;
      $display("FAIL multi_async_reset: got lvl=%h rise=%h fall=%h st=%h irq=%b required all 0",
               gpio_level_o, rise_o, fall_o, status_o, irq_o);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (fall_o !== 8'h00 || rise_o !== 8'h00 || gpio_level_o !== 8'h00 || irq_o !== 1'b0) begin
        errors++;
        $display("FAIL multi_post_reset e=%0d: got lvl=%h rise=%h fall=%h irq=%b required 00 00 00 0",
                 e, gpio_level_o, rise_o, fall_o, irq_o);
      end
    end
    $display("test_multi_reset done (checks=%0d errors=%0d)", checks, errors);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_enable();
    test_clear_vs_set();
    test_multi_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
